// File: rtl/program_seq_pkg.sv
// rtl/program_seq_pkg.sv - shared types and helpers for the program sequencer
// Purpose: FSM state type, default widths and instruction-word split helper.
package program_seq_pkg;

    localparam int SEQ_ADDR_W   = 8;
    localparam int SEQ_OPCODE_W = 4;
    localparam int SEQ_INSTR_W  = SEQ_OPCODE_W + SEQ_ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        ISSUE   = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_OPCODE_W-1:0] opcode;
        logic [SEQ_ADDR_W-1:0]   operand;
    } instr_t;

    // ROM word layout is {opcode, operand}.
    function automatic instr_t split_instr(input logic [SEQ_INSTR_W-1:0] word);
        instr_t r;
        r.opcode  = word[SEQ_INSTR_W-1 -: SEQ_OPCODE_W];
        r.operand = word[SEQ_ADDR_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// rtl/program_sequencer_return_stack.sv - LIFO of return addresses
// Purpose: DEPTH x W return stack for JMP/RTN.
// Ports: clk, rst_n (async active-low), push_i/din_i, pop_i, full_o, empty_o, top_o.
//  A push while full and a pop while empty are ignored; the caller flags the error.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] top_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr, top_ptr;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign wr_ptr  = cnt_q[PTR_W-1:0];
    // When full the low pointer bits wrap to 0, so minus one still lands on the last entry.
    assign top_ptr = wr_ptr - 1'b1;
    assign top_o   = mem_q[top_ptr];

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !full_o) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: nothing is readable until it has been pushed.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr] <= din_i;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program counter and instruction fetch for the ICU
// Purpose: fetch {opcode, operand} words from ROM at pc, issue them to the ICU with a
//  valid/ready handshake, and advance pc by increment, JMP (with return push) or RTN.
// Ports: clk, rst_n; run; ROM side mem_read/mem_addr/mem_data; ICU side instr_valid,
//  icu_ready, opcode, operand, jmp_req, rtn_req; status pc, stack_err.
module program_sequencer
    import program_seq_pkg::*;
#(
    parameter int ADDR_W      = SEQ_ADDR_W,
    parameter int OPCODE_W    = SEQ_OPCODE_W,
    parameter int STACK_DEPTH = 4,
    parameter int INSTR_W     = OPCODE_W + ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                mem_read,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [INSTR_W-1:0]  mem_data,
    output logic                instr_valid,
    input  logic                icu_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   operand,
    input  logic                jmp_req,
    input  logic                rtn_req,
    output logic [ADDR_W-1:0]   pc,
    output logic                stack_err
);

    seq_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic [ADDR_W-1:0]   operand_q;
    logic                err_q, err_d;
    instr_t              fields;

    logic                handshake;
    logic                push, pop;
    logic                stk_full, stk_empty;
    logic [ADDR_W-1:0]   stk_top;
    logic [ADDR_W-1:0]   pc_inc;

    assign fields    = split_instr(mem_data);
    assign handshake = (state_q == ISSUE) && icu_ready;
    assign pc_inc    = pc_q + 1'b1;
    // jmp_req has priority over rtn_req when both are raised.
    assign push      = handshake && jmp_req;
    assign pop       = handshake && !jmp_req && rtn_req;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (pc_inc),
        .pop_i   (pop),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .top_o   (stk_top)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        case (state_q)
            IDLE:    if (run) state_d = FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = ISSUE;
            ISSUE: begin
                if (handshake) begin
                    state_d = run ? FETCH : IDLE;
                    if (push) begin
                        pc_d = operand_q;
                        if (stk_full) err_d = 1'b1;
                    end else if (pop) begin
                        if (stk_empty) begin
                            pc_d  = '0;
                            err_d = 1'b1;
                        end else begin
                            pc_d = stk_top;
                        end
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
            if (state_q == CAPTURE) begin
                opcode_q  <= fields.opcode;
                operand_q <= fields.operand;
            end
        end
    end

    // Strobe drops in IDLE and ISSUE so every fetch gives the ROM a fresh rising edge.
    assign mem_read    = (state_q == FETCH) || (state_q == CAPTURE);
    assign mem_addr    = mem_read ? pc_q : '0;
    assign instr_valid = (state_q == ISSUE);
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign pc          = pc_q;
    assign stack_err   = err_q;

endmodule
